// File: rtl/compressor_pkg.sv
// Shared types for the LZRW group packer: buffered item record and packer FSM states.
// Item fields are sized for the widest legal configuration; the packer zero-extends.
package compressor_pkg;

    localparam int unsigned ItemOffsetW = 16;
    localparam int unsigned ItemLenW    = 8;

    typedef struct packed {
        logic                   is_copy;
        logic [7:0]             literal;
        logic [ItemOffsetW-1:0] offset;
        logic [ItemLenW-1:0]    len;
    } item_t;

    typedef enum logic [1:0] {
        StFill,
        StEmitCtrl,
        StEmitItems
    } state_e;

endpackage

// File: rtl/lzrw_item_buffer.sv
// Group item register file: one synchronous write port, one asynchronous read index.
module lzrw_item_buffer
    import compressor_pkg::*;
#(
    parameter int unsigned Depth = 16,
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic            clock,
    input  logic            wrEn_i,
    input  logic [IdxW-1:0] wrIdx_i,
    input  item_t           wrItem_i,
    input  logic [IdxW-1:0] rdIdx_i,
    output item_t           rdItem_o
);

    // Pure datapath storage; validity is tracked by the packer's item count.
    item_t mem [Depth];

    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            mem[wrIdx_i] <= wrItem_i;
        end
    end

    assign rdItem_o = mem[rdIdx_i];

endmodule

// File: rtl/lzrw_group_packer.sv
// Collects up to GROUP_SIZE literal/copy items, then emits the control bitmap bytes
// followed by the packed items as a byte stream with valid/ready handshaking.
module lzrw_group_packer
    import compressor_pkg::*;
#(
    parameter int unsigned GROUP_SIZE = 16,
    parameter int unsigned OFFSET_W   = 12,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned MIN_MATCH  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_copy,
    input  logic [7:0]          in_literal,
    input  logic [OFFSET_W-1:0] in_offset,
    input  logic [LEN_W:0]      in_len,
    input  logic                in_flush,
    input  logic                in_item,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                flush_done
);

    localparam int unsigned IdxW      = $clog2(GROUP_SIZE);
    localparam int unsigned CntW      = $clog2(GROUP_SIZE + 1);
    localparam int unsigned CtrlBytes = GROUP_SIZE / 8;
    localparam int unsigned CbW       = (CtrlBytes > 1) ? $clog2(CtrlBytes) : 1;

    state_e              stateQ, stateD;
    logic [CntW-1:0]     cntQ, cntD;
    logic [GROUP_SIZE-1:0] ctrlQ, ctrlD;
    logic                flushedQ, flushedD;
    logic [CbW-1:0]      byteIdxQ, byteIdxD;
    logic [IdxW-1:0]     rdIdxQ, rdIdxD;
    logic                halfQ, halfD;
    logic                flushDoneQ, flushDoneD;

    logic                wrEn;
    item_t               wrItem, rdItem;
    logic [ItemOffsetW-1:0] offHi;
    logic [ItemLenW-1:0] lenCode;
    logic [7:0]          copyHi, copyLo;
    logic                lastItem, itemDone, fullNow;

    assign wrItem.is_copy = in_is_copy;
    assign wrItem.literal = in_literal;
    assign wrItem.offset  = ItemOffsetW'(in_offset);
    assign wrItem.len     = ItemLenW'(in_len);

    lzrw_item_buffer #(
        .Depth (GROUP_SIZE)
    ) u_buffer (
        .clock    (clock),
        .wrEn_i   (wrEn),
        .wrIdx_i  (IdxW'(cntQ)),
        .wrItem_i (wrItem),
        .rdIdx_i  (rdIdxQ),
        .rdItem_o (rdItem)
    );

    // Copy encoding: high offset bits above the biased length, then low offset byte.
    assign lenCode  = (rdItem.len - ItemLenW'(MIN_MATCH)) & ItemLenW'((1 << LEN_W) - 1);
    assign offHi    = (rdItem.offset >> 8) << LEN_W;
    assign copyHi   = offHi[7:0] | lenCode;
    assign copyLo   = rdItem.offset[7:0];

    assign lastItem = (rdIdxQ == IdxW'(cntQ - CntW'(1)));
    assign itemDone = !rdItem.is_copy || halfQ;
    assign fullNow  = in_item && (cntQ == CntW'(GROUP_SIZE - 1));
    assign flush_done = flushDoneQ;

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        ctrlD      = ctrlQ;
        flushedD   = flushedQ;
        byteIdxD   = byteIdxQ;
        rdIdxD     = rdIdxQ;
        halfD      = halfQ;
        flushDoneD = 1'b0;
        wrEn       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;

        unique case (stateQ)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_item) begin
                        wrEn              = 1'b1;
                        ctrlD[IdxW'(cntQ)] = in_is_copy;
                        cntD              = cntQ + CntW'(1);
                    end
                    if (fullNow || (in_flush && (in_item || cntQ != '0))) begin
                        stateD   = StEmitCtrl;
                        flushedD = in_flush;
                        byteIdxD = '0;
                        rdIdxD   = '0;
                        halfD    = 1'b0;
                    end else if (in_flush) begin
                        // Empty group: nothing to emit, acknowledge straight away.
                        flushDoneD = 1'b1;
                    end
                end
            end

            StEmitCtrl: begin
                out_valid = 1'b1;
                out_data  = ctrlQ[{byteIdxQ, 3'b000} +: 8];
                if (out_ready) begin
                    if (byteIdxQ == CbW'(CtrlBytes - 1)) begin
                        stateD = StEmitItems;
                    end else begin
                        byteIdxD = byteIdxQ + CbW'(1);
                    end
                end
            end

            StEmitItems: begin
                out_valid = 1'b1;
                if (rdItem.is_copy) begin
                    out_data = halfQ ? copyLo : copyHi;
                end else begin
                    out_data = rdItem.literal;
                end
                out_last = flushedQ && lastItem && itemDone;
                if (out_ready) begin
                    if (!itemDone) begin
                        halfD = 1'b1;
                    end else begin
                        halfD = 1'b0;
                        if (lastItem) begin
                            stateD     = StFill;
                            cntD       = '0;
                            ctrlD      = '0;
                            flushedD   = 1'b0;
                            flushDoneD = flushedQ;
                        end else begin
                            rdIdxD = rdIdxQ + IdxW'(1);
                        end
                    end
                end
            end

            default: begin
                stateD = StFill;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ     <= StFill;
            cntQ       <= '0;
            ctrlQ      <= '0;
            flushedQ   <= 1'b0;
            byteIdxQ   <= '0;
            rdIdxQ     <= '0;
            halfQ      <= 1'b0;
            flushDoneQ <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            ctrlQ      <= ctrlD;
            flushedQ   <= flushedD;
            byteIdxQ   <= byteIdxD;
            rdIdxQ     <= rdIdxD;
            halfQ      <= halfD;
            flushDoneQ <= flushDoneD;
        end
    end

endmodule

// File: tb/tb_lzrw_group_packer.sv
// Directed bench for lzrw_group_packer: default 16-item instance plus a 32-item instance.
module tb_lzrw_group_packer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // 16-item instance
    logic       in_valid = 0, in_is_copy = 0, in_flush = 0, in_item = 0;
    logic [7:0] in_literal = 0;
    logic [11:0] in_offset = 0;
    logic [4:0] in_len = 5'd3;
    logic       in_ready, out_valid, out_last, flush_done;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    // 32-item instance
    logic       in_valid_w = 0, in_is_copy_w = 0, in_flush_w = 0, in_item_w = 0;
    logic [7:0] in_literal_w = 0;
    logic [11:0] in_offset_w = 0;
    logic [4:0] in_len_w = 5'd3;
    logic       in_ready_w, out_valid_w, out_last_w, flush_done_w;
    logic       out_ready_w = 1'b1;
    logic [7:0] out_data_w;

    lzrw_group_packer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_copy(in_is_copy), .in_literal(in_literal), .in_offset(in_offset),
        .in_len(in_len), .in_flush(in_flush), .in_item(in_item), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .flush_done(flush_done)
    );

    lzrw_group_packer #(.GROUP_SIZE(32)) dutWide (
        .clock(clock), .reset(reset), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .in_is_copy(in_is_copy_w), .in_literal(in_literal_w), .in_offset(in_offset_w),
        .in_len(in_len_w), .in_flush(in_flush_w), .in_item(in_item_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .out_last(out_last_w), .flush_done(flush_done_w)
    );

    int nChecks = 0;
    int nPass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor, sampled on the falling edge.
    logic [8:0] q16[$];
    logic [8:0] qw[$];
    int   lastCyc = -1, flushCyc = -1, flushCnt = 0, validCnt = 0, flushCntW = 0;
    int   lowRun = 0, maxLow = 0, acceptCyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    bit   randReady = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (stalled) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, held});
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (out_valid) validCnt++;
            if (out_valid && out_ready) begin
                q16.push_back({out_last, out_data});
                if (out_last) lastCyc = cyc;
            end
            if (flush_done) begin
                flushCyc = cyc;
                flushCnt++;
            end
            if (!in_ready) lowRun++;
            else lowRun = 0;
            if (lowRun > maxLow) maxLow = lowRun;
            if (out_valid_w && out_ready_w) qw.push_back({out_last_w, out_data_w});
            if (flush_done_w) flushCntW++;
        end else begin
            stalled = 1'b0;
        end
    end

    always @(posedge clock) begin
        #1;
        out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic isCopy, input logic [7:0] lit, input logic [11:0] off,
                        input logic [4:0] len, input logic flush, input logic item);
        bit ok = 0;
        in_valid = 1; in_is_copy = isCopy; in_literal = lit; in_offset = off;
        in_len = len; in_flush = flush; in_item = item;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                acceptCyc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        in_valid = 0; in_flush = 0; in_item = 0;
    endtask

    task automatic sendWide(input logic [11:0] off, input logic [4:0] len);
        bit ok = 0;
        in_valid_w = 1; in_is_copy_w = 1; in_offset_w = off; in_len_w = len;
        in_item_w = 1; in_flush_w = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready_w) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_wide_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        in_valid_w = 0; in_item_w = 0;
    endtask

    task automatic waitBytes(input bit wide, input int n, input string tag);
        int sz = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            sz = wide ? qw.size() : q16.size();
            if (sz >= n) break;
        end
        check(tag, sz, n);
    endtask

    task automatic sendMixed();
        send(1'b0, 8'h61, 12'h000, 5'd3, 1'b0, 1'b1);
        send(1'b1, 8'h00, 12'h123, 5'd5, 1'b0, 1'b1);
        send(1'b0, 8'h62, 12'h000, 5'd3, 1'b1, 1'b1);
    endtask

    logic [8:0] expMixed [6] = '{9'h002, 9'h000, 9'h061, 9'h012, 9'h023, 9'h162};
    logic [8:0] expAfterRst [3] = '{9'h000, 9'h000, 9'h17F};

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        @(posedge clock); #1;

        // Full group of 16 literals
        maxLow = 0; flushCnt = 0; q16.delete();
        for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h41 + i), 12'h000, 5'd3, 1'b0, 1'b1);
        waitBytes(0, 18, "full_count");
        repeat (3) @(negedge clock);
        for (int i = 0; i < 18; i++)
            check($sformatf("full_byte%0d", i), {23'd0, q16[i]},
                  (i < 2) ? 32'h000 : 32'(32'h041 + i - 2));
        check("full_ready_low", {31'd0, maxLow >= 18}, 32'd1);
        check("full_no_flush_done", flushCnt, 0);
        check("full_ready_again", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;

        // Literal, copy, literal+flush
        q16.delete(); flushCnt = 0;
        sendMixed();
        waitBytes(0, 6, "mixed_count");
        repeat (3) @(negedge clock);
        for (int i = 0; i < 6; i++)
            check($sformatf("mixed_byte%0d", i), {23'd0, q16[i]}, {23'd0, expMixed[i]});
        check("mixed_flush_cnt", flushCnt, 1);
        check("mixed_flush_timing", flushCyc, lastCyc + 1);
        @(posedge clock); #1;

        // Flush-only beat on an empty group
        flushCnt = 0; validCnt = 0;
        send(1'b0, 8'h00, 12'h000, 5'd3, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        check("empty_no_valid", validCnt, 0);
        check("empty_flush_cnt", flushCnt, 1);
        check("empty_flush_timing", flushCyc, acceptCyc + 1);
        @(posedge clock); #1;

        // Mixed stream again with random backpressure
        q16.delete(); flushCnt = 0; randReady = 1;
        sendMixed();
        waitBytes(0, 6, "stall_count");
        randReady = 0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 6; i++)
            check($sformatf("stall_byte%0d", i), {23'd0, q16[i]}, {23'd0, expMixed[i]});
        check("stall_flush_cnt", flushCnt, 1);
        @(posedge clock); #1;

        // Reset in the middle of item emission
        q16.delete();
        for (int i = 0; i < 16; i++) send(1'b0, 8'(8'h20 + i), 12'h000, 5'd3, 1'b0, 1'b1);
        waitBytes(0, 6, "rst_mid_progress");
        @(posedge clock); #1 reset = 1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1 reset = 0;
        q16.delete(); flushCnt = 0;
        @(negedge clock);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        send(1'b0, 8'h7F, 12'h000, 5'd3, 1'b1, 1'b1);
        waitBytes(0, 3, "rst_after_count");
        repeat (4) @(negedge clock);
        check("rst_after_total", q16.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("rst_after_byte%0d", i), {23'd0, q16[i]}, {23'd0, expAfterRst[i]});
        check("rst_after_flush", flushCnt, 1);
        @(posedge clock); #1;

        // 32-item group of maximal copies
        qw.delete();
        for (int i = 0; i < 32; i++) sendWide(12'hFFF, 5'd18);
        waitBytes(1, 68, "wide_count");
        repeat (3) @(negedge clock);
        for (int i = 0; i < 68; i++)
            check($sformatf("wide_byte%0d", i), {23'd0, qw[i]}, 32'h0FF);
        check("wide_no_flush_done", flushCntW, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
